// File: rtl/sw_alloc_pkg.sv
// Shared switch-allocator definitions: port sizing, flit type codes,
// output FSM state encoding and a one-hot to index helper.
`ifndef SW_VH
`define SW_VH
`define ASSERT 1'b1
`define NEGATE 1'b0
`endif

package sw_pkg;
   localparam int NPORT = 4;
   localparam int PORTW = 2;

   typedef enum logic [1:0] {
      FLIT_IDLE = 2'b00,
      FLIT_BODY = 2'b01,
      FLIT_HEAD = 2'b10,
      FLIT_TAIL = 2'b11
   } flit_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } ost_t;

   function automatic logic [PORTW-1:0] oh2idx(input logic [NPORT-1:0] oh);
      logic [PORTW-1:0] idx;
      idx = {PORTW{1'b0}};
      for (int k = 0; k < NPORT; k++) begin
         if (oh[k]) begin
            idx = idx | PORTW'(k);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction
endpackage

// File: rtl/sw_alloc_rr_arb4.sv
// Four-way round-robin picker: first set candidate at or after ptr, wrapping.
module rr_arb4
   import sw_pkg::*;
(
   input  logic [NPORT-1:0] cand,
   input  logic [PORTW-1:0] ptr,
   output logic [NPORT-1:0] win,
   output logic             valid
);

   // Scan ptr, ptr+1, ... ; the index add wraps modulo 4 by width.
   always_comb begin
      logic [PORTW-1:0] idx;
      idx   = {PORTW{1'b0}};
      win   = {NPORT{1'b0}};
      valid = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
         idx = ptr + PORTW'(k);
         if (!valid && cand[idx]) begin
            win[idx] = 1'b1;
            valid    = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/sw_alloc.sv
// Wormhole switch allocator: one IDLE/LOCK FSM per output, locked from head
// grant until the owner's tail flit, with per-output round-robin fairness.
module sw_alloc
   import sw_pkg::ost_t, sw_pkg::ST_IDLE, sw_pkg::ST_LOCK, sw_pkg::oh2idx;
#(
   parameter int NPORT = sw_pkg::NPORT,
   parameter int PORTW = sw_pkg::PORTW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NPORT-1:0] req,
   input  logic [PORTW-1:0] dst0,
   input  logic [PORTW-1:0] dst1,
   input  logic [PORTW-1:0] dst2,
   input  logic [PORTW-1:0] dst3,
   input  logic [NPORT-1:0] fv,
   input  logic [NPORT-1:0] tl,
   output logic [NPORT-1:0] gnt,
   output logic [PORTW-1:0] sel0,
   output logic [PORTW-1:0] sel1,
   output logic [PORTW-1:0] sel2,
   output logic [PORTW-1:0] sel3,
   output logic [NPORT-1:0] busy
);

   logic [PORTW-1:0] dst_s      [NPORT];
   ost_t             state_q    [NPORT];
   ost_t             state_d    [NPORT];
   logic [PORTW-1:0] owner_q    [NPORT];
   logic [PORTW-1:0] owner_d    [NPORT];
   logic [PORTW-1:0] ptr_q      [NPORT];
   logic [PORTW-1:0] ptr_d      [NPORT];
   logic [PORTW-1:0] scan_ptr_s [NPORT];
   logic [NPORT-1:0] cand_s     [NPORT];
   logic [NPORT-1:0] win_s      [NPORT];
   logic [NPORT-1:0] win_valid_s;
   logic [NPORT-1:0] release_s;
   logic [NPORT-1:0] gnt_q, gnt_d;
   logic [NPORT-1:0] busy_q, busy_d;

   assign dst_s[0] = dst0;
   assign dst_s[1] = dst1;
   assign dst_s[2] = dst2;
   assign dst_s[3] = dst3;

   // Release detection and candidates; gnt_q already marks inputs that own an output.
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         release_s[j]  = (state_q[j] == ST_LOCK) && fv[owner_q[j]] && tl[owner_q[j]];
         scan_ptr_s[j] = release_s[j] ? (owner_q[j] + PORTW'(1)) : ptr_q[j];
         for (int i = 0; i < NPORT; i++) begin
            cand_s[j][i] = req[i] && (dst_s[i] == PORTW'(j)) && !gnt_q[i];
         end
      end
   end

   for (genvar g = 0; g < NPORT; g++) begin : g_arb
      rr_arb4 u_arb (
         .cand  (cand_s[g]),
         .ptr   (scan_ptr_s[g]),
         .win   (win_s[g]),
         .valid (win_valid_s[g])
      );
   end

   // Next state: a released output can be relocked in the same cycle.
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = scan_ptr_s[j];
         if (((state_q[j] == ST_IDLE) || release_s[j]) && win_valid_s[j]) begin
            state_d[j] = ST_LOCK;
            owner_d[j] = oh2idx(win_s[j]);
         end else if (release_s[j]) begin
            state_d[j] = ST_IDLE;
         end else begin
            state_d[j] = state_q[j];
         end
      end
   end

   // Output decode from the next state so gnt/busy land with the lock.
   always_comb begin
      gnt_d  = {NPORT{1'b0}};
      busy_d = {NPORT{1'b0}};
      for (int j = 0; j < NPORT; j++) begin
         if (state_d[j] == ST_LOCK) begin
            busy_d[j]          = 1'b1;
            gnt_d[owner_d[j]]  = 1'b1;
         end else begin
            busy_d[j] = 1'b0;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NPORT; j++) begin
            state_q[j] <= ST_IDLE;
            owner_q[j] <= {PORTW{1'b0}};
            ptr_q[j]   <= {PORTW{1'b0}};
         end
         gnt_q  <= {NPORT{1'b0}};
         busy_q <= {NPORT{1'b0}};
      end else begin
         for (int j = 0; j < NPORT; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
         end
         gnt_q  <= gnt_d;
         busy_q <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign sel0 = owner_q[0];
   assign sel1 = owner_q[1];
   assign sel2 = owner_q[2];
   assign sel3 = owner_q[3];

endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: directed scenarios plus randomized
// traffic compared against a per-output lock/owner/pointer reference model.
module tb_sw_alloc;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, fv, tl, gnt, busy;
   logic [1:0] dst_a [4];
   logic [1:0] sel_o [4];
   int         checks = 0;
   int         errors = 0;

   bit m_lock [4];
   int m_own  [4];
   int m_ptr  [4];
   int rem    [4];

   sw_alloc #(.NPORT(4), .PORTW(2)) dut (
      .clk(clk), .rst(rst), .req(req),
      .dst0(dst_a[0]), .dst1(dst_a[1]), .dst2(dst_a[2]), .dst3(dst_a[3]),
      .fv(fv), .tl(tl), .gnt(gnt),
      .sel0(sel_o[0]), .sel1(sel_o[1]), .sel2(sel_o[2]), .sel3(sel_o[3]),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_gnt();
      logic [3:0] v = 4'b0000;
      for (int j = 0; j < 4; j++) if (m_lock[j]) v[m_own[j]] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] exp_busy();
      logic [3:0] v = 4'b0000;
      for (int j = 0; j < 4; j++) v[j] = m_lock[j];
      return v;
   endfunction

   // Advance one clock; the model applies the allocation rules to the inputs seen at the edge.
   task automatic cycle();
      bit owned [4];
      bit n_lock [4];
      int n_own [4];
      int n_ptr [4];
      bit rel;
      int w, i;
      for (int k = 0; k < 4; k++) owned[k] = 1'b0;
      for (int j = 0; j < 4; j++) if (m_lock[j]) owned[m_own[j]] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         n_lock[j] = m_lock[j]; n_own[j] = m_own[j]; n_ptr[j] = m_ptr[j];
         if (rst) begin
            n_lock[j] = 1'b0; n_own[j] = 0; n_ptr[j] = 0;
         end else begin
            rel = m_lock[j] && fv[m_own[j]] && tl[m_own[j]];
            if (rel) n_ptr[j] = (m_own[j] + 1) % 4;
            w = -1;
            if (!m_lock[j] || rel) begin
               for (int k = 0; k < 4; k++) begin
                  i = (n_ptr[j] + k) % 4;
                  if (w < 0 && req[i] && int'(dst_a[i]) == j && !owned[i]) w = i;
               end
            end
            if (w >= 0) begin
               n_lock[j] = 1'b1; n_own[j] = w;
            end else if (rel) begin
               n_lock[j] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
         m_lock[j] = n_lock[j]; m_own[j] = n_own[j]; m_ptr[j] = n_ptr[j];
      end
   endtask

   task automatic clear_inputs();
      req = 4'b0000; fv = 4'b0000; tl = 4'b0000;
      for (int k = 0; k < 4; k++) dst_a[k] = 2'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      req = 4'b1111;
      for (int k = 0; k < 4; k++) dst_a[k] = 2'd1;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (gnt !== 4'b0000 || busy !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt_busy: gnt=%b busy=%b, required 0000/0000", gnt, busy);
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (sel_o[j] !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel%0d: got %0d, required 0", j, sel_o[j]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_single_packet();
      do_reset();
      req = 4'b0001; dst_a[0] = 2'd1;
      cycle();
      checks++;
      if (gnt !== 4'b0001 || busy !== 4'b0010 || sel_o[1] !== 2'd0) begin
         errors++;
         $display("FAIL single_grant: gnt=%b busy=%b sel1=%0d, required 0001/0010/0", gnt, busy, sel_o[1]);
      end
      req = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         fv = 4'b0001;
         tl = (k == 4) ? 4'b0001 : 4'b0000;
         cycle();
         checks++;
         if (k < 4 && (busy !== 4'b0010 || gnt !== 4'b0001)) begin
            errors++;
            $display("FAIL single_hold_%0d: gnt=%b busy=%b, required 0001/0010", k, gnt, busy);
         end else if (k == 4 && (busy !== 4'b0000 || gnt !== 4'b0000)) begin
            errors++;
            $display("FAIL single_release: gnt=%b busy=%b, required 0000/0000", gnt, busy);
         end
      end
      clear_inputs();
   endtask

   task automatic test_conflict();
      logic [3:0] ev;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 4; k++) dst_a[k] = 2'd1;
      cycle();
      req[0] = 1'b0;
      for (int p = 0; p < 4; p++) begin
         ev = 4'b0001 << p;
         fv = ev; tl = 4'b0000;
         cycle();
         checks++;
         if (gnt !== ev || busy !== 4'b0010 || sel_o[1] !== 2'(p)) begin
            errors++;
            $display("FAIL conflict_hold_%0d: gnt=%b busy=%b sel1=%0d, required %b/0010/%0d", p, gnt, busy, sel_o[1], ev, p);
         end
         fv = ev; tl = ev;
         cycle();
         checks++;
         if (p < 3) begin
            if (gnt !== (ev << 1) || busy !== 4'b0010 || sel_o[1] !== 2'(p + 1)) begin
               errors++;
               $display("FAIL conflict_next_%0d: gnt=%b busy=%b sel1=%0d, required %b/0010/%0d", p, gnt, busy, sel_o[1], ev << 1, p + 1);
            end
            req[p + 1] = 1'b0;
         end else if (gnt !== 4'b0000 || busy !== 4'b0000 || sel_o[1] !== 2'd3) begin
            errors++;
            $display("FAIL conflict_end: gnt=%b busy=%b sel1=%0d, required 0000/0000/3", gnt, busy, sel_o[1]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_fairness();
      do_reset();
      req = 4'b0100; dst_a[2] = 2'd0;
      cycle();
      checks++;
      if (gnt !== 4'b0100 || sel_o[0] !== 2'd2) begin
         errors++;
         $display("FAIL fair_first: gnt=%b sel0=%0d, required 0100/2", gnt, sel_o[0]);
      end
      req = 4'b0000; fv = 4'b0100;
      cycle();
      fv = 4'b0100; tl = 4'b0100;
      req = 4'b1010; dst_a[1] = 2'd0; dst_a[3] = 2'd0;
      cycle();
      checks++;
      if (gnt !== 4'b1000 || sel_o[0] !== 2'd3 || busy !== 4'b0001) begin
         errors++;
         $display("FAIL fair_winner: gnt=%b sel0=%0d busy=%b, required 1000/3/0001", gnt, sel_o[0], busy);
      end
      req = 4'b0010; fv = 4'b1000; tl = 4'b0000;
      cycle();
      fv = 4'b1000; tl = 4'b1000;
      cycle();
      checks++;
      if (gnt !== 4'b0010 || sel_o[0] !== 2'd1) begin
         errors++;
         $display("FAIL fair_second: gnt=%b sel0=%0d, required 0010/1", gnt, sel_o[0]);
      end
      clear_inputs();
   endtask

   task automatic test_parallel();
      do_reset();
      req = 4'b1111;
      dst_a[0] = 2'd3; dst_a[1] = 2'd2; dst_a[2] = 2'd1; dst_a[3] = 2'd0;
      cycle();
      checks++;
      if (gnt !== 4'b1111 || busy !== 4'b1111 || sel_o[3] !== 2'd0 || sel_o[2] !== 2'd1
          || sel_o[1] !== 2'd2 || sel_o[0] !== 2'd3) begin
         errors++;
         $display("FAIL parallel: gnt=%b busy=%b sel3..0=%0d,%0d,%0d,%0d, required 1111/1111/0,1,2,3",
                  gnt, busy, sel_o[3], sel_o[2], sel_o[1], sel_o[0]);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0001; dst_a[0] = 2'd2;
      cycle();
      req = 4'b0000; fv = 4'b0001;
      cycle();
      fv = 4'b0001; rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++;
      if (busy !== 4'b0000 || gnt !== 4'b0000 || sel_o[2] !== 2'd0) begin
         errors++;
         $display("FAIL rstmid_abort: gnt=%b busy=%b sel2=%0d, required 0000/0000/0", gnt, busy, sel_o[2]);
      end
      fv = 4'b0000; req = 4'b0010; dst_a[1] = 2'd2;
      cycle();
      checks++;
      if (gnt !== 4'b0010 || busy !== 4'b0100 || sel_o[2] !== 2'd1) begin
         errors++;
         $display("FAIL rstmid_regrant: gnt=%b busy=%b sel2=%0d, required 0010/0100/1", gnt, busy, sel_o[2]);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      logic [3:0] pre_g, post_g;
      bit         was_rst;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         pre_g = exp_gnt();
         for (int i = 0; i < 4; i++) begin
            if (pre_g[i]) begin
               req[i]   = 1'($urandom_range(0, 1));
               dst_a[i] = 2'($urandom_range(0, 3));
               fv[i]    = ($urandom_range(0, 3) != 0);
               tl[i]    = fv[i] && (rem[i] == 1);
            end else begin
               if (!req[i] && $urandom_range(0, 2) == 0) begin
                  req[i]   = 1'b1;
                  dst_a[i] = 2'($urandom_range(0, 3));
               end
               fv[i] = 1'($urandom_range(0, 1));
               tl[i] = 1'($urandom_range(0, 1));
            end
         end
         rst = ($urandom_range(0, 99) == 0);
         was_rst = rst;
         cycle();
         rst = 1'b0;
         post_g = exp_gnt();
         for (int i = 0; i < 4; i++) begin
            if (pre_g[i] && fv[i] && !was_rst) rem[i]--;
            if (post_g[i] && !pre_g[i]) rem[i] = $urandom_range(2, 5);
         end
         checks++;
         if (gnt !== exp_gnt() || busy !== exp_busy()) begin
            errors++;
            $display("FAIL random_gnt_busy cycle %0d: gnt=%b busy=%b, required %b/%b", n, gnt, busy, exp_gnt(), exp_busy());
         end
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (sel_o[j] !== 2'(m_own[j])) begin
               errors++;
               $display("FAIL random_sel%0d cycle %0d: got %0d, required %0d", j, n, sel_o[j], m_own[j]);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      for (int j = 0; j < 4; j++) begin
         m_lock[j] = 1'b0; m_own[j] = 0; m_ptr[j] = 0; rem[j] = 0;
      end
      @(posedge clk);
      #1;
      test_reset();
      test_single_packet();
      test_conflict();
      test_fairness();
      test_parallel();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sw_alloc.md
SW_ALLOC -- requirements
Module: sw_alloc

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of input and output ports; only 4 is required to work.
REQ-002 SHALL have parameter PORTW, default 2, width of a port index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high (`ASSERT = 1).
REQ-005 SHALL have port req  input  4  req[i] = input i has a head flit waiting.
REQ-006 SHALL have ports dst0..dst3  input  2 each  destination output of input i's waiting packet; valid only when req[i]=1.
REQ-007 SHALL have port fv  input  4  fv[i] = input i sends a flit this cycle.
REQ-008 SHALL have port tl  input  4  tl[i] = the flit sent by input i this cycle is a tail (type 11).
REQ-009 SHALL have port gnt  output  4  gnt[i] = input i owns an output and may send flits.
REQ-010 SHALL have ports sel0..sel3  output  2 each  index of the input driving output j.
REQ-011 SHALL have port busy  output  4  busy[j] = output j is locked to an input.

Function
REQ-012 SHALL keep one FSM per output j with states IDLE and LOCK, plus a 2-bit owner and a 2-bit round-robin pointer ptr_j.
REQ-013 SHALL mark input i as a candidate for output j when req[i]=1, dst_i=j and input i owns no output.
REQ-014 SHALL pick the winner for free output j as the first candidate found scanning ptr_j, ptr_j+1, ... modulo 4.
REQ-015 SHALL treat output j as free in a cycle if it is in IDLE, or it is in LOCK and its owner has fv=1 and tl=1 in that cycle.
REQ-016 SHALL, at the edge after a winner is found, enter LOCK with owner = winner; gnt, sel and busy SHALL reflect this one cycle after req is presented (1-cycle latency).
REQ-017 SHALL return output j to IDLE at the edge where its owner has fv=1 and tl=1, and SHALL then set ptr_j = owner+1 modulo 4.
REQ-018 SHALL, if output j is released and has another candidate in the same cycle, lock it to that candidate at the same edge; back-to-back packets have no idle bubble.
REQ-019 SHALL derive the new-grant scan in a release cycle from the updated pointer (owner+1), never from the old one.
REQ-020 SHALL grant each input at most one output, and each output to at most one input.
REQ-021 SHALL ignore fv and tl from an input that is not granted.
REQ-022 SHALL ignore req from an input that is already granted; its next head flit competes only after its tail.
REQ-023 SHALL arbitrate each output independently; a conflict on one output SHALL NOT stall grants to other outputs.
REQ-024 SHALL hold sel_j at its last owner value while output j is IDLE.
REQ-025 SHALL require a packet length of at least 2 flits (head plus tail).

Reset
REQ-026 SHALL, while rst=1 at a clock edge, force every FSM to IDLE and set every owner and ptr to 0; gnt, busy and all sel outputs SHALL read 0 in the following cycle.
REQ-027 SHALL abort in-flight packets when rst is asserted mid-packet, and SHALL keep no lock after rst is deasserted.
REQ-028 SHALL ignore req, fv and tl in any cycle where rst=1.

Structure
REQ-029 SHALL place NPORT, PORTW, the flit type codes (00 idle, 10 head, 01 body, 11 tail) and the IDLE/LOCK state enum in the shared package sw_pkg; `ASSERT and `NEGATE SHALL stay in sw.vh.
REQ-030 SHALL instantiate sub-module rr_arb4 four times, once per output; each instance takes a 4-bit candidate vector and a pointer and returns a one-hot winner plus a valid flag.

Verification
REQ-031 Reset: assert rst for 1 cycle with req=1111 -> gnt=0000, busy=0000, sel=0 on every output.
REQ-032 Single packet: req[0]=1 and dst0=1 at cycle N, then 4 flits with tail at cycle N+4 -> gnt[0]=1, sel1=0 and busy[1]=1 from N+1; busy[1]=0 at N+5.
REQ-033 Conflict: req=1111 with all dst=1 and 2-flit packets -> grants issued in order input 0,1,2,3, each held 2 cycles, with no gap between packets.
REQ-034 Fairness: after input 2 releases output 0, inputs 1 and 3 both request output 0 -> input 3 wins.
REQ-035 Parallel: inputs 0,1,2,3 request outputs 3,2,1,0 at the same time -> all four granted in the same cycle, with sel3=0, sel2=1, sel1=2, sel0=3.
REQ-036 Reset mid-packet: rst during the second flit of a packet -> busy=0 after the reset edge, and a new request is granted 1 cycle after rst deasserts.
